// File: rtl/wishbone_bus_if_pkg.sv
// Shared types and constants for the per-stage Wishbone classic master.
//   wb_state_e : bus-cycle FSM states
//   wb_req_t   : registered bus request payload (addr/data/we/sel)
package wishbone_bus_if_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SEL_W   = 4;
   localparam int unsigned STALL_W = 6;

   localparam logic STOP       = 1'b1;
   localparam logic NO_STOP    = 1'b0;
   localparam logic RST_ENABLE = 1'b0;   // reset is active-low

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      WB_IDLE           = 2'b00,
      WB_BUSY           = 2'b01,
      WB_WAIT_FOR_STALL = 2'b11
   } wb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              we;
      logic [SEL_W-1:0]  sel;
   } wb_req_t;

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic master for one pipeline stage. Turns a stage memory
// request into a single bus cycle, stalls the stage while it is outstanding,
// and holds read data while the stage itself is frozen by the controller.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   stall_i, flush_i    controller stall vector and flush
//   cpu_*_i             stage request (ce/addr/data/we/sel)
//   cpu_data_o          read data back to the stage (combinational)
//   stallreq_o          stall request to the controller (combinational)
//   wishbone_*          bus side; all *_o registered
module wishbone_bus_if
   import wishbone_bus_if_pkg::*;
#(
   parameter int unsigned STALL_IDX = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               cpu_ce_i,
   input  logic [ADDR_W-1:0]  cpu_addr_i,
   input  logic [DATA_W-1:0]  cpu_data_i,
   input  logic               cpu_we_i,
   input  logic [SEL_W-1:0]   cpu_sel_i,
   output logic [DATA_W-1:0]  cpu_data_o,
   output logic               stallreq_o,
   input  logic [DATA_W-1:0]  wishbone_data_i,
   input  logic               wishbone_ack_i,
   output logic [ADDR_W-1:0]  wishbone_addr_o,
   output logic [DATA_W-1:0]  wishbone_data_o,
   output logic               wishbone_we_o,
   output logic [SEL_W-1:0]   wishbone_sel_o,
   output logic               wishbone_stb_o,
   output logic               wishbone_cyc_o
);

   wb_state_e         state_q, state_d;
   wb_req_t           req_q, req_d;
   logic              stb_q, stb_d;
   logic              cyc_q, cyc_d;
   logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

   logic stage_stalled;
   logic unused_stall;

   assign stage_stalled = stall_i[STALL_IDX];
   assign unused_stall  = ^stall_i;

   // State and bus registers
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q  <= WB_IDLE;
         req_q    <= '0;
         stb_q    <= 1'b0;
         cyc_q    <= 1'b0;
         rd_buf_q <= ZERO_WORD;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         stb_q    <= stb_d;
         cyc_q    <= cyc_d;
         rd_buf_q <= rd_buf_d;
      end
   end

   // Next state, next bus values and stage-facing outputs
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      stb_d      = stb_q;
      cyc_d      = cyc_q;
      rd_buf_d   = rd_buf_q;
      stallreq_o = NO_STOP;
      cpu_data_o = ZERO_WORD;

      unique case (state_q)
         WB_IDLE: begin
            req_d = '0;
            stb_d = 1'b0;
            cyc_d = 1'b0;
            if (cpu_ce_i && !flush_i) begin
               req_d.addr = cpu_addr_i;
               req_d.data = cpu_data_i;
               req_d.we   = cpu_we_i;
               req_d.sel  = cpu_sel_i;
               stb_d      = 1'b1;
               cyc_d      = 1'b1;
               rd_buf_d   = ZERO_WORD;
               state_d    = WB_BUSY;
               // Stall in the request cycle so the stage cannot advance early
               stallreq_o = STOP;
            end
         end

         WB_BUSY: begin
            if (flush_i) begin
               // Abort; any ack data in this cycle is dropped
               req_d    = '0;
               stb_d    = 1'b0;
               cyc_d    = 1'b0;
               rd_buf_d = ZERO_WORD;
               state_d  = WB_IDLE;
            end else if (wishbone_ack_i) begin
               req_d = '0;
               stb_d = 1'b0;
               cyc_d = 1'b0;
               if (!req_q.we) begin
                  rd_buf_d   = wishbone_data_i;
                  cpu_data_o = wishbone_data_i;
               end
               state_d = stage_stalled ? WB_WAIT_FOR_STALL : WB_IDLE;
            end else begin
               stallreq_o = STOP;
            end
         end

         WB_WAIT_FOR_STALL: begin
            // Stage is frozen by someone else; keep presenting the acked word
            cpu_data_o = rd_buf_q;
            if (flush_i) begin
               rd_buf_d = ZERO_WORD;
               state_d  = WB_IDLE;
            end else if (!stage_stalled) begin
               state_d = WB_IDLE;
            end
         end

         default: begin
            state_d = WB_IDLE;
         end
      endcase

      if (rst == RST_ENABLE) begin
         stallreq_o = NO_STOP;
         cpu_data_o = ZERO_WORD;
      end
   end

   assign wishbone_addr_o = req_q.addr;
   assign wishbone_data_o = req_q.data;
   assign wishbone_we_o   = req_q.we;
   assign wishbone_sel_o  = req_q.sel;
   assign wishbone_stb_o  = stb_q;
   assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if (IF instance, STALL_IDX = 1).
// Read data expected by the stage is queued when a read is issued and
// popped when the acked word should appear on cpu_data_o.
module tb_wishbone_bus_if;

   logic        clk;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        cpu_ce_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic [31:0] wishbone_data_i;
   logic        wishbone_ack_i;
   logic [31:0] wishbone_addr_o;
   logic [31:0] wishbone_data_o;
   logic        wishbone_we_o;
   logic [3:0]  wishbone_sel_o;
   logic        wishbone_stb_o;
   logic        wishbone_cyc_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_word;

   wishbone_bus_if #(.STALL_IDX(1)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .cpu_ce_i        (cpu_ce_i),
      .cpu_addr_i      (cpu_addr_i),
      .cpu_data_i      (cpu_data_i),
      .cpu_we_i        (cpu_we_i),
      .cpu_sel_i       (cpu_sel_i),
      .cpu_data_o      (cpu_data_o),
      .stallreq_o      (stallreq_o),
      .wishbone_data_i (wishbone_data_i),
      .wishbone_ack_i  (wishbone_ack_i),
      .wishbone_addr_o (wishbone_addr_o),
      .wishbone_data_o (wishbone_data_o),
      .wishbone_we_o   (wishbone_we_o),
      .wishbone_sel_o  (wishbone_sel_o),
      .wishbone_stb_o  (wishbone_stb_o),
      .wishbone_cyc_o  (wishbone_cyc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bus_idle(input string tag);
      chk({tag, "_stb"},  32'(wishbone_stb_o), 32'd0);
      chk({tag, "_cyc"},  32'(wishbone_cyc_o), 32'd0);
      chk({tag, "_addr"}, wishbone_addr_o,     32'd0);
      chk({tag, "_data"}, wishbone_data_o,     32'd0);
      chk({tag, "_we"},   32'(wishbone_we_o),  32'd0);
      chk({tag, "_sel"},  32'(wishbone_sel_o), 32'd0);
   endtask

   initial begin
      rst = 1'b0; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0;
      cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0;
      wishbone_data_i = '0; wishbone_ack_i = 1'b0;

      // Reset state
      next_cyc(); next_cyc(); #1;
      chk_bus_idle("rst");
      chk("rst_stallreq", 32'(stallreq_o), 32'd0);
      chk("rst_cpu_data", cpu_data_o, 32'd0);
      rst = 1'b1;

      // Read, ack three cycles after stb rises
      next_cyc();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100; cpu_sel_i = 4'hF;
      exp_q.push_back(32'hDEAD_BEEF);
      #1;
      chk("rd_req_stallreq", 32'(stallreq_o), 32'd1);
      chk("rd_req_stb", 32'(wishbone_stb_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         next_cyc(); #1;
         chk("rd_wait_stallreq", 32'(stallreq_o), 32'd1);
         chk("rd_wait_stb", 32'(wishbone_stb_o), 32'd1);
         chk("rd_wait_cyc", 32'(wishbone_cyc_o), 32'd1);
         chk("rd_wait_addr", wishbone_addr_o, 32'h0000_0100);
         chk("rd_wait_we", 32'(wishbone_we_o), 32'd0);
         chk("rd_wait_cpu_data", cpu_data_o, 32'd0);
      end
      next_cyc();
      cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEAD_BEEF;
      #1;
      exp_word = exp_q.pop_front();
      chk("rd_ack_stallreq", 32'(stallreq_o), 32'd0);
      chk("rd_ack_cpu_data", cpu_data_o, exp_word);
      next_cyc();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0;
      #1;
      chk_bus_idle("rd_done");
      chk("rd_done_cpu_data", cpu_data_o, 32'd0);

      // Write to a zero-wait slave
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h80;
      cpu_data_i = 32'h1234_5678; cpu_sel_i = 4'b0011;
      #1;
      chk("wr_req_stallreq", 32'(stallreq_o), 32'd1);
      next_cyc();
      cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1;
      #1;
      chk("wr_addr", wishbone_addr_o, 32'h80);
      chk("wr_data", wishbone_data_o, 32'h1234_5678);
      chk("wr_we", 32'(wishbone_we_o), 32'd1);
      chk("wr_sel", 32'(wishbone_sel_o), 32'h3);
      chk("wr_stb", 32'(wishbone_stb_o), 32'd1);
      chk("wr_ack_stallreq", 32'(stallreq_o), 32'd0);
      chk("wr_ack_cpu_data", cpu_data_o, 32'd0);
      next_cyc();
      wishbone_ack_i = 1'b0; cpu_we_i = 1'b0; cpu_data_i = '0; cpu_sel_i = 4'hF;
      #1;
      chk_bus_idle("wr_done");

      // IF read acked while the stage is frozen by a MEM stall
      stall_i = 6'b011111;
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h200;
      exp_q.push_back(32'hA5A5_5A5A);
      #1;
      chk("ws_req_stallreq", 32'(stallreq_o), 32'd1);
      next_cyc();
      cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hA5A5_5A5A;
      #1;
      exp_word = exp_q.pop_front();
      chk("ws_ack_cpu_data", cpu_data_o, exp_word);
      chk("ws_ack_stallreq", 32'(stallreq_o), 32'd0);
      next_cyc();
      wishbone_ack_i = 1'b0; wishbone_data_i = 32'h1111_1111;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("ws_hold_cpu_data", cpu_data_o, exp_word);
         chk("ws_hold_stallreq", 32'(stallreq_o), 32'd0);
         chk("ws_hold_stb", 32'(wishbone_stb_o), 32'd0);
         next_cyc(); #1;
      end
      stall_i = '0;
      #1;
      chk("ws_release_cpu_data", cpu_data_o, exp_word);
      next_cyc();
      // Back in IDLE: word no longer presented, a new request stalls at once
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h300; wishbone_data_i = '0;
      #1;
      chk("ws_idle_cpu_data", cpu_data_o, 32'd0);
      chk("ws_idle_stallreq", 32'(stallreq_o), 32'd1);

      // Flush two cycles into BUSY, then a late ack
      next_cyc();
      cpu_ce_i = 1'b0;
      #1;
      chk("fl_busy_stb", 32'(wishbone_stb_o), 32'd1);
      chk("fl_busy_addr", wishbone_addr_o, 32'h300);
      chk("fl_busy_stallreq", 32'(stallreq_o), 32'd1);
      next_cyc();
      flush_i = 1'b1;
      #1;
      chk("fl_stallreq", 32'(stallreq_o), 32'd0);
      next_cyc();
      flush_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0000_0BAD;
      #1;
      chk_bus_idle("fl_after");
      chk("fl_late_ack_cpu_data", cpu_data_o, 32'd0);
      chk("fl_late_ack_stallreq", 32'(stallreq_o), 32'd0);
      next_cyc();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0;
      #1;
      chk("fl_late_ack_stb", 32'(wishbone_stb_o), 32'd0);

      // Flush and ack together: data discarded
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; cpu_we_i = 1'b0;
      #1;
      next_cyc();
      cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; flush_i = 1'b1; wishbone_data_i = 32'hCAFE_0000;
      #1;
      chk("fa_cpu_data", cpu_data_o, 32'd0);
      chk("fa_stallreq", 32'(stallreq_o), 32'd0);
      next_cyc();
      wishbone_ack_i = 1'b0; flush_i = 1'b0; wishbone_data_i = '0;
      #1;
      chk_bus_idle("fa_after");

      // Reset asserted mid-BUSY
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h500;
      cpu_data_i = 32'h5555_AAAA; cpu_sel_i = 4'hF;
      #1;
      next_cyc();
      cpu_ce_i = 1'b0;
      #1;
      chk("rb_busy_stb", 32'(wishbone_stb_o), 32'd1);
      chk("rb_busy_stallreq", 32'(stallreq_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("rb_stallreq_now", 32'(stallreq_o), 32'd0);
      chk("rb_cpu_data_now", cpu_data_o, 32'd0);
      next_cyc(); #1;
      chk_bus_idle("rb_after");
      rst = 1'b1;
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h600; cpu_data_i = '0;
      exp_q.push_back(32'h600D_F00D);
      #1;
      chk("rb_new_stallreq", 32'(stallreq_o), 32'd1);
      next_cyc();
      cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h600D_F00D;
      #1;
      chk("rb_new_addr", wishbone_addr_o, 32'h600);
      chk("rb_new_stb", 32'(wishbone_stb_o), 32'd1);
      exp_word = exp_q.pop_front();
      chk("rb_new_cpu_data", cpu_data_o, exp_word);
      next_cyc();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0;
      #1;
      chk("rb_new_done_stb", 32'(wishbone_stb_o), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wishbone_bus_if.md
Name: wishbone_bus_if

Overview:
- Per-stage Wishbone B4 classic master that turns a pipeline-stage memory request into a bus cycle.
- Asserts stallreq_o toward the pipeline controller while the bus cycle is outstanding.
- Obeys the controller's stall vector and flush in return.
- Two instances: instruction-fetch side (stall bit 1) and data-memory side (stall bit 3).

Parameters:
STALL_IDX, 1, index into stall_i that freezes the owning stage (1 = IF, 3 = MEM)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
stall_i  in  6  stall vector from the pipeline controller
flush_i  in  1  pipeline flush from the controller (exception/eret)
cpu_ce_i  in  1  stage requests a memory access this cycle
cpu_addr_i  in  32  request byte address
cpu_data_i  in  32  write data
cpu_we_i  in  1  1 = write, 0 = read
cpu_sel_i  in  4  byte lane select
cpu_data_o  out  32  read data returned to the stage
stallreq_o  out  1  stall request to the controller (1 = Stop)
wishbone_data_i  in  32  bus read data
wishbone_ack_i  in  1  bus acknowledge
wishbone_addr_o  out  32  bus address (registered)
wishbone_data_o  out  32  bus write data (registered)
wishbone_we_o  out  1  bus write enable (registered)
wishbone_sel_o  out  4  bus byte select (registered)
wishbone_stb_o  out  1  bus strobe (registered)
wishbone_cyc_o  out  1  bus cycle (registered)

Behaviour:
- State register, 2 bits: IDLE, BUSY, WAIT_FOR_STALL.
- rd_buf: 32-bit register holding read data.
- Reset (rst == 0 at posedge):
  - state = IDLE.
  - All wishbone_*_o = 0.
  - rd_buf = 0.
  - While rst == 0, stallreq_o = 0 and cpu_data_o = 0 combinationally.

Registered transitions:
- IDLE, cpu_ce_i = 1 and flush_i = 0:
  - Load addr/data/we/sel from cpu_* inputs.
  - stb = cyc = 1.
  - rd_buf = 0.
  - Go to BUSY.
- IDLE, otherwise: hold, bus outputs stay 0.
- BUSY, flush_i = 1 (regardless of ack):
  - Abort: stb = cyc = we = 0, addr/data/sel = 0.
  - rd_buf = 0.
  - Go to IDLE.
  - Ack-data arriving in the same cycle is discarded.
- BUSY, wishbone_ack_i = 1, no flush:
  - Drop stb/cyc and clear addr/data/we/sel.
  - If the cycle was a read, rd_buf = wishbone_data_i.
  - If stall_i[STALL_IDX] == 1, go to WAIT_FOR_STALL; else go to IDLE.
- BUSY, no ack: hold all bus outputs stable (Wishbone rule: master signals constant until ack).
- WAIT_FOR_STALL, stall_i[STALL_IDX] == 0: go to IDLE.
- WAIT_FOR_STALL, flush_i = 1: rd_buf = 0, go to IDLE.
- WAIT_FOR_STALL, otherwise: hold.

Combinational outputs (rst == 1):
- IDLE:
  - stallreq_o = cpu_ce_i & ~flush_i, so the stall is raised in the same cycle the request appears.
  - cpu_data_o = 0.
- BUSY, ack = 1 and flush = 0:
  - stallreq_o = 0.
  - cpu_data_o = wishbone_data_i if a read, else 0.
- BUSY, no ack:
  - stallreq_o = 1.
  - cpu_data_o = 0.
- WAIT_FOR_STALL:
  - stallreq_o = 0.
  - cpu_data_o = rd_buf, stable until the stage advances.
- flush_i = 1 in any state: stallreq_o = 0.

Timing:
- Minimum latency is request cycle + 1 bus cycle: a zero-wait slave acks in the cycle after stb rises, and the stage advances on that edge.
- Only one outstanding cycle at a time; no pipelined Wishbone.
- wishbone_ack_i is ignored outside BUSY.
- A new cpu_ce_i is only sampled in IDLE.

Decomposition:
- defines.v:
  - state encodings WB_IDLE 2'b00, WB_BUSY 2'b01, WB_WAIT_FOR_STALL 2'b11.
  - existing Stop/NoStop, ZeroWord, RegBus, and a new RstEnable-compatible active-low macro.
- No sub-module: one state register, one buffer, one output decode.

Test Plan:
- Read, ack 3 cycles after stb:
  - Stimulus: cpu_ce = 1, we = 0, addr = 0x0000_0100, slave returns 0xDEADBEEF.
  - Response: stallreq_o = 1 for 4 cycles; cpu_data_o = 0xDEADBEEF in the ack cycle; stb/cyc drop next edge.
- Write, zero-wait slave:
  - Stimulus: addr = 0x80, data = 0x1234_5678, sel = 4'b0011.
  - Response: bus outputs match for exactly 1 cycle; stallreq_o deasserts in the ack cycle; cpu_data_o = 0.
- IF read acked while stall_i = 6'b011111 (MEM stall):
  - Response: enter WAIT_FOR_STALL; cpu_data_o holds the acked word for every stalled cycle.
  - Response: return to IDLE the cycle after stall_i[1] clears.
- flush_i = 1 two cycles into BUSY:
  - Response: stb/cyc = 0 next edge; a late ack is ignored; stallreq_o = 0; state IDLE.
- flush_i and ack in the same cycle:
  - Stimulus: read data 0xCAFE0000.
  - Response: data not returned; rd_buf = 0.
- rst = 0 asserted mid-BUSY:
  - Response: all wishbone_*_o = 0 next edge; stallreq_o = 0 immediately.
  - Response: after release, a new request starts cleanly.
